// File: rtl/rotator_pkg.sv
// Shared constants and types for the rotator arbiter slice.
package rotator_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  localparam int unsigned PerfCntWidth = 16;

  // Output register occupancy; the encoding doubles as out_valid.
  typedef enum logic {StEmpty, StFull} out_state_e;

endpackage

// File: rtl/rotator_arbiter_if.sv
// Handshake bundle between the two requesters, the consumer and the rotator arbiter.
interface rotator_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned SHW = $clog2(WIDTH);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic [SHW-1:0]   req0_shamt;
  logic             req0_left;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic [SHW-1:0]   req1_shamt;
  logic             req1_left;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;

  // Client side: requesters and the result consumer.
  modport master (
    output req0_valid, req0_data, req0_shamt, req0_left,
    output req1_valid, req1_data, req1_shamt, req1_left,
    output out_ready,
    input  req0_ready, req1_ready,
    input  out_valid, out_data, out_id
  );

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_left,
    input  req1_valid, req1_data, req1_shamt, req1_left,
    input  out_ready,
    output req0_ready, req1_ready,
    output out_valid, out_data, out_id
  );

endinterface

// File: rtl/rotator_core.sv
// Combinational WIDTH-bit left/right rotator; the single shared datapath.
module rotator_core
  import rotator_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [SHW-1:0]   shamt,
  input  logic             left,
  output logic [WIDTH-1:0] result
);

  logic [SHW-1:0] pos;
  logic [SHW-1:0] src;

  // WIDTH is a power of two, so SHW-bit index arithmetic wraps modulo WIDTH.
  always_comb begin
    result = '0;
    pos    = '0;
    src    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos       = SHW'(i);
      src       = (left == DIR_LEFT) ? pos - shamt : pos + shamt;
      result[i] = data[src];
    end
  end

endmodule

// File: rtl/rotator_arbiter.sv
// Round-robin arbiter sharing one rotator between two requesters, registered output.
// Optional grant counters when ROTATOR_ARB_PERF_CNT_EN is defined.
module rotator_arbiter
  import rotator_pkg::*;
#(
  parameter  int unsigned WIDTH = 4,
  localparam int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  rotator_arbiter_if.slave        bus
`ifdef ROTATOR_ARB_PERF_CNT_EN
  ,
  output logic [PerfCntWidth-1:0] grant_cnt0,
  output logic [PerfCntWidth-1:0] grant_cnt1
`endif
);

  out_state_e       state_q;
  logic [WIDTH-1:0] data_q;
  logic             id_q;
  logic             last_q;

  logic             can_accept;
  logic             grant0;
  logic             grant1;
  logic             fire;
  logic             sel_id;
  logic [WIDTH-1:0] sel_data;
  logic [SHW-1:0]   sel_shamt;
  logic             sel_left;
  logic [WIDTH-1:0] rot_result;

  assign can_accept = (state_q == StEmpty) | bus.out_ready;

  // On contention the requester not granted last wins.
  assign grant0 = bus.req0_valid & (~bus.req1_valid | (last_q == REQ1));
  assign grant1 = bus.req1_valid & (~bus.req0_valid | (last_q == REQ0));

  assign bus.req0_ready = grant0 & can_accept & ~reset;
  assign bus.req1_ready = grant1 & can_accept & ~reset;
  assign fire           = bus.req0_ready | bus.req1_ready;

  assign sel_id    = grant1 ? REQ1 : REQ0;
  assign sel_data  = grant1 ? bus.req1_data  : bus.req0_data;
  assign sel_shamt = grant1 ? bus.req1_shamt : bus.req0_shamt;
  assign sel_left  = grant1 ? bus.req1_left  : bus.req0_left;

  rotator_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .data  (sel_data),
    .shamt (sel_shamt),
    .left  (sel_left),
    .result(rot_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
      id_q    <= REQ0;
      last_q  <= REQ1;
    end else begin
      if (fire) begin
        data_q <= rot_result;
        id_q   <= sel_id;
        last_q <= sel_id;
      end
      unique case (state_q)
        StEmpty: if (fire) state_q <= StFull;
        StFull:  if (!fire && bus.out_ready) state_q <= StEmpty;
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign bus.out_valid = (state_q == StFull);
  assign bus.out_data  = data_q;
  assign bus.out_id    = id_q;

`ifdef ROTATOR_ARB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (bus.req0_ready && (grant_cnt0 != '1)) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (bus.req1_ready && (grant_cnt1 != '1)) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule
